spi_counter_slave: RTL

SPI mode-0 slave that receives the 14-bit run/stop counter value sent by the master as two bytes, high byte first, and presents it as a registered parallel word with a one-cycle valid strobe. It sits on the receiving board between the SPI pins and the display or counter-consumer logic. It is the receiving end of the master's SEND_HIGH/SEND_LOW byte sequence.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_slave_byte_rx.sv | 70 +++++++
 rtl/spi_counter_slave.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI counter slave: word FSM states and field sizes.
package spi_pkg;

    typedef enum logic {
        RX_HIGH,
        RX_LOW
    } rx_state_e;

    localparam int SPI_BYTE_W = 8;
    localparam int CNT_W      = 14;
    localparam int HI_BITS    = 6;

endpackage

// File: rtl/spi_slave_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the pins, detects SCLK/SS edges and
// shifts MOSI into bytes, flagging completed bytes and aborted partial bytes.
module spi_slave_byte_rx
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss,
    output logic [SPI_BYTE_W-1:0] rx_byte,
    output logic                  byte_done,
    output logic                  partial_abort,
    output logic                  sclk_rise,
    output logic                  sclk_fall,
    output logic                  ss_fall,
    output logic                  ss_active,
    output logic [2:0]            bit_cnt
);

    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [1:0] ss_sync;
    logic       sclk_prev;
    logic       ss_prev;
    logic       ss_rise;

    // SS synchronizer resets to the idle (deselected) level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            ss_sync   <= 2'b11;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            ss_sync   <= {ss_sync[0], ss};
            sclk_prev <= sclk_sync[1];
            ss_prev   <= ss_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    assign ss_rise   = ss_sync[1] & ~ss_prev;
    assign ss_fall   = ~ss_sync[1] & ss_prev;
    assign ss_active = ~ss_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte       <= '0;
            bit_cnt       <= 3'd0;
            byte_done     <= 1'b0;
            partial_abort <= 1'b0;
        end else begin
            byte_done     <= 1'b0;
            partial_abort <= ss_rise && (bit_cnt != 3'd0);
            if (ss_sync[1]) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                rx_byte   <= {rx_byte[SPI_BYTE_W-2:0], mosi_sync[1]};
                bit_cnt   <= bit_cnt + 3'd1;
                byte_done <= (bit_cnt == 3'd7);
            end
        end
    end

endmodule

// File: rtl/spi_counter_slave.sv
// Receives a 14-bit counter as two SPI bytes (high first) and presents it with a valid strobe.
// Optional MISO echo of the previous byte is enabled by defining SPI_SLAVE_MISO_ECHO_EN.
module spi_counter_slave
    import spi_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 200_000
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss,
    output logic             miso,
    output logic [CNT_W-1:0] o_counter,
    output logic             o_valid,
    output logic             o_frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [SPI_BYTE_W-1:0] rx_byte;
    logic                  byte_done;
    logic                  partial_abort;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  ss_fall;
    logic                  ss_active;
    logic [2:0]            bit_cnt;

    rx_state_e             state;
    rx_state_e             next_state;
    logic [HI_BITS-1:0]    hi6;
    logic [TO_W-1:0]       timeout_cnt;
    logic                  timeout_hit;
    logic                  load_hi;
    logic                  load_counter;
    logic                  valid_next;
    logic                  err_next;

    spi_slave_byte_rx u_byte_rx (
        .clk           (clk),
        .reset         (reset),
        .sclk          (sclk),
        .mosi          (mosi),
        .ss            (ss),
        .rx_byte       (rx_byte),
        .byte_done     (byte_done),
        .partial_abort (partial_abort),
        .sclk_rise     (sclk_rise),
        .sclk_fall     (sclk_fall),
        .ss_fall       (ss_fall),
        .ss_active     (ss_active),
        .bit_cnt       (bit_cnt)
    );

    assign timeout_hit = (state == RX_LOW) && (timeout_cnt == TO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (reset || state != RX_LOW || sclk_rise) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= timeout_cnt + TO_W'(1);
        end
    end

    // A completed byte takes priority over a timeout landing in the same cycle.
    always_comb begin
        next_state   = state;
        load_hi      = 1'b0;
        load_counter = 1'b0;
        valid_next   = 1'b0;
        err_next     = partial_abort;
        case (state)
            RX_HIGH: begin
                if (byte_done) begin
                    if (rx_byte[SPI_BYTE_W-1:HI_BITS] == '0) begin
                        load_hi    = 1'b1;
                        next_state = RX_LOW;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RX_LOW: begin
                if (byte_done) begin
                    load_counter = 1'b1;
                    valid_next   = 1'b1;
                    next_state   = RX_HIGH;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    next_state = RX_HIGH;
                end
            end
            default: next_state = RX_HIGH;
        endcase
        if (valid_next) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RX_HIGH;
            hi6         <= '0;
            o_counter   <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= next_state;
            o_valid     <= valid_next;
            o_frame_err <= err_next;
            if (load_hi) begin
                hi6 <= rx_byte[HI_BITS-1:0];
            end
            if (load_counter) begin
                o_counter <= {hi6, rx_byte};
            end
        end
    end

`ifdef SPI_SLAVE_MISO_ECHO_EN
    logic [SPI_BYTE_W-1:0] echo_byte;
    logic [SPI_BYTE_W-1:0] tx_shift;

    // A falling edge with the bit counter at zero ends a byte, so the fresh echo byte is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_byte <= '0;
            tx_shift  <= '0;
        end else begin
            if (byte_done) begin
                echo_byte <= rx_byte;
            end
            if (ss_fall) begin
                tx_shift <= echo_byte;
            end else if (sclk_fall && ss_active) begin
                if (bit_cnt == 3'd0) begin
                    tx_shift <= echo_byte;
                end else begin
                    tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                end
            end
        end
    end

    assign miso = ss_active & tx_shift[SPI_BYTE_W-1];
`else
    logic unused_echo;

    assign unused_echo = ^{sclk_fall, ss_fall, ss_active, bit_cnt};
    assign miso        = 1'b0;
`endif

endmodule
